pre_norm_fmul_pipe: RTL and testbench
=====================================

// Module: pre_norm_fmul_pipe
// PURPOSE
//  Parametrised, handshaked successor of the FPU multiply/divide pre-normaliser. Unpacks two IEEE-style
//  operands, restores hidden bits, computes the signed biased result exponent, sign and special-case flags.
//  It is a 2-stage valid/ready pipeline with full backpressure, feeding the mul/div core and post-normaliser.
//  It replaces the fixed 32-bit, always-enabled pre-normaliser and its 2-bit overflow / 3-bit underflow encoding.
// PARAMETERS
//  EXP_W   8   exponent field width; BIAS = 2**(EXP_W-1)-1
//  FRAC_W  23  stored fraction width; operand width W = 1+EXP_W+FRAC_W
//  TAG_W   4   width of the opaque tag carried alongside each operation
// PORTS
//  clk        in   1          rising-edge clock
//  rst_n      in   1          asynchronous active-low reset
//  in_valid   in   1          operation presented
//  in_ready   out  1          pipeline accepts the operation this cycle
//  fpu_op     in   3          fpu_op_e; only FPU_DIV (3'b011) selects divide, every other code selects multiply
//  opa, opb   in   W          operands {sign, exp, frac}
//  in_tag     in   TAG_W      passed through unchanged
//  out_valid  out  1          result valid
//  out_ready  in   1          consumer accepts the result
//  fracta/b   out  FRAC_W+1   {exp!=0, frac}
//  exp_out    out  EXP_W+2    two's-complement biased exponent, never truncated
//  sign       out  1          signa ^ signb
//  sign_exe   out  1          signa & signb
//  op_div     out  1          registered divide select
//  flags      out  fpu_pre_flags_t {ovf, unf, dn_a, dn_b, zero_a, zero_b, inf_a, inf_b, nan_a, nan_b, div_zero}
//  out_tag    out  TAG_W      tag of the result
// BEHAVIOUR
//  Reset: every stage valid bit, every output and every data register is 0. in_ready is 1 one cycle after release.
//  Exponent: Ea = (ea==0) ? 1 : ea, and Eb likewise, both zero-extended to EXP_W+2 bits.
//    MUL: exp_out = Ea + Eb - BIAS.   DIV: exp_out = Ea - Eb + BIAS.
//  Exponent flags:
//    ovf = exp_out >= 2**EXP_W-1 (signed compare).
//    unf = exp_out <= 0, and neither operand is zero.
//  Classification flags:
//    dn_x   = exp==0 and frac!=0.   zero_x = exp==0 and frac==0.
//    inf_x  = exp all-ones and frac==0.   nan_x = exp all-ones and frac!=0.
//    div_zero = op_div & zero_b & !zero_a & !nan_a.
//  Stage 1 (S1): registers the operands, op_div and tag, plus the classify results.
//  Stage 2 (S2): registers the exponent, flags, fractions and sign.
//  Latency: 2 cycles from the in_valid&in_ready edge to out_valid with no stall.
//    Throughput is 1 operation per cycle.
//  Handshake: adv2 = !s2_v | out_ready;  adv1 = !s1_v | adv2;  in_ready = adv1.
//  While out_valid & !out_ready, all outputs hold stable and nothing is dropped or duplicated.
//  Order is strictly FIFO. At most 2 operations are in flight.
//  Simultaneous accept and emit with the pipe full advances both stages in the same cycle.
//  rst_n low mid-operation discards in-flight operations immediately, and outputs go to reset values asynchronously.
//  in_valid is ignored while rst_n is low.
// STRUCTURE
//  fpu_pkg contents:
//    fpu_op_e {FPU_ADD=0, FPU_SUB=1, FPU_MUL=2, FPU_DIV=3}, fpu_pre_flags_t packed struct.
//    Functions bias_f(EXP_W) and fp_w_f(EXP_W, FRAC_W).
//  Sub-module fp_classify: purely combinational, instanced once per operand.
//    Parameters EXP_W and FRAC_W. Outputs dn, zero, inf, nan and the hidden bit.
//  Top level holds the two pipeline stages and the handshake logic.
// TESTING (defaults EXP_W=8, FRAC_W=23)
//  1. MUL 0x40400000 * 0x40000000, out_ready=1:
//     out_valid 2 cycles later, exp_out=129, fracta=0xC00000, fractb=0x800000, sign=0, flags all 0.
//  2. DIV 0x3F800000 / 0x00000000:
//     exp_out=253, zero_b=1, div_zero=1, ovf=0.
//  3. MUL 0x7F000000 * 0x7F000000:
//     exp_out=381 (10'h17D), ovf=1.
//     MUL 0x00800000 * 0x00800000: exp_out=-125, unf=1.
//  4. MUL 0x00000001 * 0x3F800000:
//     fracta=0x000001, dn_a=1, exp_out=1.
//     MUL 0xFF800000 * 0x80000000: inf_a=1, zero_b=1, sign=0, sign_exe=1.
//  5. Backpressure: stream 4 tagged ops (tags 1-4) with out_ready=0 for 5 cycles:
//     in_ready drops after 2 accepts, outputs stay stable.
//     After out_ready=1, tags emerge in order 1,2,3,4 with none lost or repeated.
//  6. Pull rst_n low while out_valid=1 and S1 is full:
//     out_valid=0 and exp_out=0 with no clock edge needed.
//     After release, first new op appears after 2 cycles with no stale data.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared FPU types and parameter helpers for the multiply/divide pre-normaliser.
// Flag struct bit order: ovf is the MSB, div_zero is the LSB.
package fpu_pkg;

    typedef enum logic [2:0] {
        FPU_ADD = 3'd0,
        FPU_SUB = 3'd1,
        FPU_MUL = 3'd2,
        FPU_DIV = 3'd3
    } fpu_op_e;

    typedef struct packed {
        logic ovf;
        logic unf;
        logic dn_a;
        logic dn_b;
        logic zero_a;
        logic zero_b;
        logic inf_a;
        logic inf_b;
        logic nan_a;
        logic nan_b;
        logic div_zero;
    } fpu_pre_flags_t;

    // Per-operand classification bundle carried from stage 1 into stage 2.
    typedef struct packed {
        logic dn;
        logic zero;
        logic inf;
        logic nan;
        logic hidden;
    } fp_class_t;

    function automatic int bias_f(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    function automatic int fp_w_f(input int exp_w, input int frac_w);
        return 1 + exp_w + frac_w;
    endfunction

endpackage

// File: rtl/fp_classify.sv
// Combinational classification of one IEEE-style operand: denormal, zero, inf, NaN and
// the hidden bit that is restored in front of the stored fraction.
module fp_classify #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
) (
    input  logic [EXP_W-1:0]  exp_f,
    input  logic [FRAC_W-1:0] frac,
    output logic              dn,
    output logic              zero,
    output logic              inf,
    output logic              nan,
    output logic              hidden
);

    logic exp_zero;
    logic exp_ones;
    logic frac_zero;

    assign exp_zero  = (exp_f == '0);
    assign exp_ones  = &exp_f;
    assign frac_zero = (frac == '0);

    assign dn     = exp_zero & ~frac_zero;
    assign zero   = exp_zero & frac_zero;
    assign inf    = exp_ones & frac_zero;
    assign nan    = exp_ones & ~frac_zero;
    assign hidden = ~exp_zero;

endmodule

// File: rtl/pre_norm_fmul_pipe.sv
// Two-stage valid/ready pre-normaliser for the mul/div core: stage 1 captures operands and
// their classification, stage 2 produces the biased exponent, sign, fractions and flags.
module pre_norm_fmul_pipe
    import fpu_pkg::*;
#(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23,
    parameter int TAG_W  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           fpu_op,
    input  logic [fp_w_f(EXP_W, FRAC_W)-1:0] opa,
    input  logic [fp_w_f(EXP_W, FRAC_W)-1:0] opb,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [FRAC_W:0]      fracta,
    output logic [FRAC_W:0]      fractb,
    output logic [EXP_W+1:0]     exp_out,
    output logic                 sign,
    output logic                 sign_exe,
    output logic                 op_div,
    output fpu_pre_flags_t       flags,
    output logic [TAG_W-1:0]     out_tag
);

    localparam int W    = fp_w_f(EXP_W, FRAC_W);
    localparam int BIAS = bias_f(EXP_W);
    localparam int EW   = EXP_W + 2;

    fp_class_t cls_a;
    fp_class_t cls_b;

    fp_classify #(.EXP_W(EXP_W), .FRAC_W(FRAC_W)) u_class_a (
        .exp_f  (opa[W-2 -: EXP_W]),
        .frac   (opa[FRAC_W-1:0]),
        .dn     (cls_a.dn),
        .zero   (cls_a.zero),
        .inf    (cls_a.inf),
        .nan    (cls_a.nan),
        .hidden (cls_a.hidden)
    );

    fp_classify #(.EXP_W(EXP_W), .FRAC_W(FRAC_W)) u_class_b (
        .exp_f  (opb[W-2 -: EXP_W]),
        .frac   (opb[FRAC_W-1:0]),
        .dn     (cls_b.dn),
        .zero   (cls_b.zero),
        .inf    (cls_b.inf),
        .nan    (cls_b.nan),
        .hidden (cls_b.hidden)
    );

    logic              rdy_en;
    logic              s1_v;
    logic [W-1:0]      s1_opa;
    logic [W-1:0]      s1_opb;
    logic              s1_div;
    logic [TAG_W-1:0]  s1_tag;
    fp_class_t         s1_cls_a;
    fp_class_t         s1_cls_b;
    logic              s2_v;

    logic adv1;
    logic adv2;
    logic accept;

    assign adv2      = ~s2_v | out_ready;
    assign adv1      = ~s1_v | adv2;
    assign in_ready  = rdy_en & adv1;
    assign accept    = in_valid & in_ready;
    assign out_valid = s2_v;

    // Stage 1 register plus the ready enable that keeps in_ready low until a clock after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_en   <= 1'b0;
            s1_v     <= 1'b0;
            s1_opa   <= '0;
            s1_opb   <= '0;
            s1_div   <= 1'b0;
            s1_tag   <= '0;
            s1_cls_a <= '0;
            s1_cls_b <= '0;
        end else begin
            rdy_en <= 1'b1;
            if (adv1) begin
                s1_v <= accept;
            end
            if (accept) begin
                s1_opa   <= opa;
                s1_opb   <= opb;
                s1_div   <= (fpu_op == FPU_DIV);
                s1_tag   <= in_tag;
                s1_cls_a <= cls_a;
                s1_cls_b <= cls_b;
            end
        end
    end

    logic [EW-1:0]  ea_ext;
    logic [EW-1:0]  eb_ext;
    logic [EW-1:0]  exp_calc;
    fpu_pre_flags_t flags_calc;

    // Denormals and zeros use an effective exponent of 1; the result is two's complement.
    always_comb begin
        ea_ext   = s1_cls_a.hidden ? {2'b00, s1_opa[W-2 -: EXP_W]} : EW'(1);
        eb_ext   = s1_cls_b.hidden ? {2'b00, s1_opb[W-2 -: EXP_W]} : EW'(1);
        exp_calc = s1_div ? (ea_ext - eb_ext + EW'(BIAS))
                          : (ea_ext + eb_ext - EW'(BIAS));

        flags_calc          = '0;
        flags_calc.ovf      = ~exp_calc[EW-1] & (exp_calc >= EW'((1 << EXP_W) - 1));
        flags_calc.unf      = (exp_calc[EW-1] | (exp_calc == '0))
                              & ~s1_cls_a.zero & ~s1_cls_b.zero;
        flags_calc.dn_a     = s1_cls_a.dn;
        flags_calc.dn_b     = s1_cls_b.dn;
        flags_calc.zero_a   = s1_cls_a.zero;
        flags_calc.zero_b   = s1_cls_b.zero;
        flags_calc.inf_a    = s1_cls_a.inf;
        flags_calc.inf_b    = s1_cls_b.inf;
        flags_calc.nan_a    = s1_cls_a.nan;
        flags_calc.nan_b    = s1_cls_b.nan;
        flags_calc.div_zero = s1_div & s1_cls_b.zero & ~s1_cls_a.zero & ~s1_cls_a.nan;
    end

    // Stage 2 register drives every result output directly and holds while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_v     <= 1'b0;
            fracta   <= '0;
            fractb   <= '0;
            exp_out  <= '0;
            sign     <= 1'b0;
            sign_exe <= 1'b0;
            op_div   <= 1'b0;
            flags    <= '0;
            out_tag  <= '0;
        end else if (adv2) begin
            s2_v <= s1_v;
            if (s1_v) begin
                fracta   <= {s1_cls_a.hidden, s1_opa[FRAC_W-1:0]};
                fractb   <= {s1_cls_b.hidden, s1_opb[FRAC_W-1:0]};
                exp_out  <= exp_calc;
                sign     <= s1_opa[W-1] ^ s1_opb[W-1];
                sign_exe <= s1_opa[W-1] & s1_opb[W-1];
                op_div   <= s1_div;
                flags    <= flags_calc;
                out_tag  <= s1_tag;
            end
        end
    end

endmodule

// File: tb/tb_pre_norm_fmul_pipe.sv
// Self-checking bench for pre_norm_fmul_pipe: directed cases, backpressure, async reset and
// a randomized handshake run scored against a behavioural model.
module tb_pre_norm_fmul_pipe;
    import fpu_pkg::*;

    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;
    localparam int TAG_W  = 4;
    localparam int VW     = TAG_W + 2 * (FRAC_W + 1) + (EXP_W + 2) + 3 + 11;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [2:0]          fpu_op = 3'd2;
    logic [31:0]         opa = '0;
    logic [31:0]         opb = '0;
    logic [TAG_W-1:0]    in_tag = '0;
    logic                out_valid;
    logic                out_ready = 1'b0;
    logic [FRAC_W:0]     fracta;
    logic [FRAC_W:0]     fractb;
    logic [EXP_W+1:0]    exp_out;
    logic                sign;
    logic                sign_exe;
    logic                op_div;
    fpu_pre_flags_t      flags;
    logic [TAG_W-1:0]    out_tag;

    int compared = 0;
    int mismatched = 0;

    pre_norm_fmul_pipe #(.EXP_W(EXP_W), .FRAC_W(FRAC_W), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .fpu_op    (fpu_op),
        .opa       (opa),
        .opb       (opb),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .fracta    (fracta),
        .fractb    (fractb),
        .exp_out   (exp_out),
        .sign      (sign),
        .sign_exe  (sign_exe),
        .op_div    (op_div),
        .flags     (flags),
        .out_tag   (out_tag)
    );

    always #5 clk = ~clk;

    logic [VW-1:0] dut_vec;
    assign dut_vec = {out_tag, fracta, fractb, exp_out, sign, sign_exe, op_div, flags};

    task automatic check_output(input string tag, input logic [127:0] got, input logic [127:0] want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    // Result computed straight from the arithmetic rules with integers.
    function automatic logic [VW-1:0] model(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [TAG_W-1:0] tag);
        int ea, eb, fa, fb, eff_a, eff_b, e;
        bit div, za, zb, dna, dnb, ia, ib, na, nb, ovf, unf, dz;
        logic [9:0] e10;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        fa = int'(a[22:0]);
        fb = int'(b[22:0]);
        div = (op == 3'd3);
        za  = (ea == 0) && (fa == 0);
        zb  = (eb == 0) && (fb == 0);
        dna = (ea == 0) && (fa != 0);
        dnb = (eb == 0) && (fb != 0);
        ia  = (ea == 255) && (fa == 0);
        ib  = (eb == 255) && (fb == 0);
        na  = (ea == 255) && (fa != 0);
        nb  = (eb == 255) && (fb != 0);
        eff_a = (ea == 0) ? 1 : ea;
        eff_b = (eb == 0) ? 1 : eb;
        e   = div ? (eff_a - eff_b + 127) : (eff_a + eff_b - 127);
        e10 = e[9:0];
        ovf = (e >= 255);
        unf = (e <= 0) && !za && !zb;
        dz  = div && zb && !za && !na;
        return {tag, (ea != 0), a[22:0], (eb != 0), b[22:0], e10,
                a[31] ^ b[31], a[31] & b[31], div,
                ovf, unf, dna, dnb, za, zb, ia, ib, na, nb, dz};
    endfunction

    function automatic logic [31:0] gen_operand();
        logic [7:0]  e;
        logic [22:0] f;
        logic        s;
        case ($urandom_range(0, 5))
            0:       e = 8'd0;
            1:       e = 8'd255;
            2:       e = 8'd1;
            3:       e = 8'd254;
            default: e = 8'($urandom_range(0, 255));
        endcase
        f = ($urandom_range(0, 2) == 0) ? 23'd0 : 23'($urandom);
        s = 1'($urandom_range(0, 1));
        return {s, e, f};
    endfunction

    // One operation into an empty pipe; leaves the result held at the output.
    task automatic apply_stimulus(input logic [2:0] op, input logic [31:0] a,
                                  input logic [31:0] b, input logic [TAG_W-1:0] tag);
        int n;
        logic [VW-1:0] want;
        @(negedge clk);
        fpu_op = op; opa = a; opb = b; in_tag = tag;
        in_valid = 1'b1; out_ready = 1'b0;
        #1;
        check_output("accept ready", in_ready, 1);
        want = model(op, a, b, tag);
        @(negedge clk);
        in_valid = 1'b0;
        n = 1;
        #1;
        while (!out_valid && n < 10) begin
            @(negedge clk);
            n++;
            #1;
        end
        check_output("latency", n, 2);
        check_output("result", dut_vec, want);
    endtask

    task automatic release_out();
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        check_output("drained", out_valid, 0);
    endtask

    task automatic backpressure_test();
        int sent = 0;
        logic [VW-1:0] snap;
        logic [TAG_W-1:0] got_tags[$];
        out_ready = 1'b0;
        fpu_op = 3'd2; opa = 32'h40400000; opb = 32'h40000000;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_tag = TAG_W'(sent + 1);
            #1;
            if (c == 2) snap = dut_vec;
            if (c > 2) check_output("bp hold", dut_vec, snap);
            if (in_ready) sent++;
        end
        check_output("bp accepts", sent, 2);
        check_output("bp in_ready", in_ready, 0);
        check_output("bp head tag", out_tag, 1);
        for (int c = 0; c < 20 && got_tags.size() < 4; c++) begin
            @(negedge clk);
            out_ready = 1'b1;
            in_valid = (sent < 4);
            in_tag = TAG_W'(sent + 1);
            #1;
            if (in_valid && in_ready) sent++;
            if (out_valid) got_tags.push_back(out_tag);
        end
        in_valid = 1'b0;
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        check_output("bp count", got_tags.size(), 4);
        for (int i = 0; i < got_tags.size(); i++)
            check_output("bp order", got_tags[i], i + 1);
        check_output("bp empty", out_valid, 0);
    endtask

    task automatic reset_test();
        out_ready = 1'b0;
        fpu_op = 3'd2; opa = 32'h7F000000; opb = 32'h7F000000;
        @(negedge clk); in_valid = 1'b1; in_tag = 4'd5;
        @(negedge clk); in_tag = 4'd6;
        @(negedge clk); in_valid = 1'b0;
        #1;
        check_output("rst pre out_valid", out_valid, 1);
        check_output("rst pre in_ready", in_ready, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("rst async out_valid", out_valid, 0);
        check_output("rst async exp_out", exp_out, 0);
        check_output("rst async tag", out_tag, 0);
        check_output("rst async in_ready", in_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check_output("rst ready after", in_ready, 1);
        check_output("rst no stale", out_valid, 0);
        apply_stimulus(3'd2, 32'h40400000, 32'h40000000, 4'd9);
        check_output("rst new tag", out_tag, 9);
        release_out();
    endtask

    task automatic random_test(input int cycles);
        logic [VW-1:0] sb[$];
        logic [VW-1:0] held_vec;
        logic [VW-1:0] want;
        bit held = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            in_valid  = ($urandom_range(0, 3) != 0);
            fpu_op    = 3'($urandom_range(0, 7));
            opa       = gen_operand();
            opb       = gen_operand();
            in_tag    = TAG_W'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (held) check_output("rnd hold", dut_vec, held_vec);
            check_output("rnd in_ready", in_ready, (sb.size() < 2) || out_ready);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) check_output("rnd spurious", 1, 0);
                else begin
                    want = sb.pop_front();
                    check_output("rnd result", dut_vec, want);
                end
            end
            if (in_valid && in_ready) sb.push_back(model(fpu_op, opa, opb, in_tag));
            held = out_valid && !out_ready;
            held_vec = dut_vec;
        end
        for (int i = 0; i < 20 && sb.size() > 0; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            out_ready = 1'b1;
            #1;
            if (out_valid) begin
                want = sb.pop_front();
                check_output("drain result", dut_vec, want);
            end
        end
        check_output("scoreboard empty", sb.size(), 0);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        #1;
        check_output("reset out_valid", out_valid, 0);
        check_output("reset in_ready", in_ready, 0);
        check_output("reset exp_out", exp_out, 0);
        check_output("reset flags", flags, 0);
        check_output("reset fracta", fracta, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check_output("ready after release", in_ready, 1);

        apply_stimulus(3'd2, 32'h40400000, 32'h40000000, 4'd1);
        check_output("t1 exp_out", exp_out, 129);
        check_output("t1 fracta", fracta, 24'hC00000);
        check_output("t1 fractb", fractb, 24'h800000);
        check_output("t1 sign", sign, 0);
        check_output("t1 flags", flags, 0);
        release_out();

        apply_stimulus(3'd3, 32'h3F800000, 32'h00000000, 4'd2);
        check_output("t2 exp_out", exp_out, 253);
        check_output("t2 zero_b", flags.zero_b, 1);
        check_output("t2 div_zero", flags.div_zero, 1);
        check_output("t2 ovf", flags.ovf, 0);
        check_output("t2 op_div", op_div, 1);
        release_out();

        apply_stimulus(3'd2, 32'h7F000000, 32'h7F000000, 4'd3);
        check_output("t3 exp_out", exp_out, 10'h17D);
        check_output("t3 ovf", flags.ovf, 1);
        release_out();

        apply_stimulus(3'd2, 32'h00800000, 32'h00800000, 4'd4);
        check_output("t3 neg exp_out", exp_out, 10'h383);
        check_output("t3 unf", flags.unf, 1);
        release_out();

        apply_stimulus(3'd2, 32'h00000001, 32'h3F800000, 4'd5);
        check_output("t4 fracta", fracta, 24'h000001);
        check_output("t4 dn_a", flags.dn_a, 1);
        check_output("t4 exp_out", exp_out, 1);
        release_out();

        apply_stimulus(3'd2, 32'hFF800000, 32'h80000000, 4'd6);
        check_output("t4 inf_a", flags.inf_a, 1);
        check_output("t4 zero_b", flags.zero_b, 1);
        check_output("t4 sign", sign, 0);
        check_output("t4 sign_exe", sign_exe, 1);
        release_out();

        backpressure_test();
        reset_test();
        random_test(600);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
